// File: rtl/mod_reduce_seq.sv
// Sequential modular reducer: product mod modulus by restoring shift-subtract,
// one product bit per clock, valid/ready handshakes on input and output.
module mod_reduce_seq #(
  parameter int unsigned lpm_widthp         = 16,
  parameter int unsigned lpm_widthm         = 8,
  parameter int unsigned modulus            = 251,
  parameter string       lpm_representation = "UNSIGNED"
) (
  input  logic                  clock,
  input  logic                  aclr,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [lpm_widthp-1:0] product,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [lpm_widthm-1:0] residue,
  output logic                  busy
);

  localparam int unsigned AccW     = lpm_widthm + 1;
  localparam int unsigned CntW     = (lpm_widthp > 1) ? $clog2(lpm_widthp) : 1;
  localparam bit          IsSigned = (lpm_representation == "SIGNED");

  localparam logic [AccW-1:0] ModAcc = AccW'(modulus);
  localparam logic [CntW-1:0] CntTop = CntW'(lpm_widthp - 1);

  if (modulus < 2 || 64'(modulus) >= (64'd1 << lpm_widthm)) begin : g_bad_modulus
    $error("mod_reduce_seq: modulus must satisfy 2 <= modulus < 2**lpm_widthm");
  end

  if (lpm_representation != "UNSIGNED" && lpm_representation != "SIGNED") begin : g_bad_repr
    $error("mod_reduce_seq: lpm_representation must be \"UNSIGNED\" or \"SIGNED\"");
  end

  typedef enum logic [1:0] {StIdle, StRun, StFix, StDone} state_e;

  state_e                  state_q;
  logic [lpm_widthp-1:0]   mag_q;
  logic [AccW-1:0]         acc_q;
  logic [CntW-1:0]         cnt_q;
  logic                    neg_q;

  logic                    in_neg;
  logic [lpm_widthp-1:0]   in_mag;
  logic [AccW-1:0]         acc_shift;
  logic [AccW-1:0]         acc_next;
  logic [AccW-1:0]         fix_val;

  // Magnitude of the incoming product; most-negative value maps to its unsigned magnitude.
  always_comb begin
    in_neg = IsSigned && product[lpm_widthp-1];
    in_mag = product;
    if (in_neg) begin
      in_mag = lpm_widthp'(0) - product;
    end
  end

  // One restoring step and the final sign correction.
  always_comb begin
    acc_shift = (acc_q << 1) | AccW'(mag_q[cnt_q]);
    acc_next  = acc_shift;
    if (acc_shift >= ModAcc) begin
      acc_next = acc_shift - ModAcc;
    end
    fix_val = acc_q;
    if (neg_q && (acc_q != '0)) begin
      fix_val = ModAcc - acc_q;
    end
  end

  // Control FSM with registered outputs and datapath state.
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      state_q   <= StIdle;
      mag_q     <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      out_valid <= 1'b0;
      residue   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            mag_q   <= in_mag;
            neg_q   <= in_neg;
            acc_q   <= '0;
            cnt_q   <= CntTop;
            state_q <= StRun;
          end
        end
        StRun: begin
          acc_q <= acc_next;
          if (cnt_q == '0) begin
            state_q <= StFix;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        StFix: begin
          residue   <= lpm_widthm'(fix_val);
          out_valid <= 1'b1;
          state_q   <= StDone;
        end
        StDone: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready = (state_q == StIdle) & ~aclr;
  assign busy     = (state_q == StRun) || (state_q == StFix);

endmodule

// File: tb/tb_mod_reduce_seq.sv
// Bench for mod_reduce_seq: an UNSIGNED and a SIGNED instance share stimulus and
// are checked against a plain-arithmetic modulo model.
module tb_mod_reduce_seq;

  logic        clock;
  logic        aclr;
  logic        in_valid;
  logic [15:0] product;
  logic        out_ready;

  logic        u_in_ready, u_out_valid, u_busy;
  logic [7:0]  u_residue;
  logic        s_in_ready, s_out_valid, s_busy;
  logic [7:0]  s_residue;

  int vectors = 0;
  int errs    = 0;
  int cyc     = 0;
  int acc_cyc = 0;

  mod_reduce_seq #(
    .lpm_widthp(16), .lpm_widthm(8), .modulus(251), .lpm_representation("UNSIGNED")
  ) u_dut (
    .clock(clock), .aclr(aclr), .in_valid(in_valid), .in_ready(u_in_ready),
    .product(product), .out_valid(u_out_valid), .out_ready(out_ready),
    .residue(u_residue), .busy(u_busy)
  );

  mod_reduce_seq #(
    .lpm_widthp(16), .lpm_widthm(8), .modulus(251), .lpm_representation("SIGNED")
  ) s_dut (
    .clock(clock), .aclr(aclr), .in_valid(in_valid), .in_ready(s_in_ready),
    .product(product), .out_valid(s_out_valid), .out_ready(out_ready),
    .residue(s_residue), .busy(s_busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  // Mathematical (non-negative) residue of the product under either interpretation.
  function automatic int ref_mod(input logic [15:0] p, input bit sgn);
    int v;
    v = sgn ? int'($signed(p)) : int'({16'd0, p});
    v = v % 251;
    if (v < 0) v += 251;
    return v;
  endfunction

  // One full transaction; hold = cycles of backpressure with a competing in_valid.
  task automatic run_txn(input logic [15:0] p, input int hold, input bit timed);
    int n, lat, busy_cnt;
    logic [7:0] hu, hs;
    @(negedge clock);
    product  = p;
    in_valid = 1'b1;
    n = 0;
    while (!(u_in_ready && s_in_ready) && n < 50) begin
      @(negedge clock);
      n++;
    end
    vectors++;
    if (u_in_ready !== 1'b1 || s_in_ready !== 1'b1) begin
      errs++;
      $display("FAIL accept: in_ready u=%b s=%b, required 1", u_in_ready, s_in_ready);
    end
    @(posedge clock);
    #1;
    acc_cyc  = cyc;
    in_valid = 1'b0;
    product  = 'x;
    busy_cnt = (u_busy === 1'b1) ? 1 : 0;
    lat = 0;
    while (u_out_valid !== 1'b1 && lat < 40) begin
      @(posedge clock);
      #1;
      lat++;
      if (u_busy === 1'b1) busy_cnt++;
    end
    if (timed) begin
      vectors++;
      if (lat != 17) begin
        errs++;
        $display("FAIL latency: got %0d edges, required 17", lat);
      end
      vectors++;
      if (busy_cnt != 17) begin
        errs++;
        $display("FAIL busy_cycles: got %0d, required 17", busy_cnt);
      end
    end
    vectors++;
    if (u_out_valid !== 1'b1 || s_out_valid !== 1'b1) begin
      errs++;
      $display("FAIL out_valid: u=%b s=%b, required 1", u_out_valid, s_out_valid);
    end
    vectors++;
    if (u_residue !== 8'(ref_mod(p, 1'b0))) begin
      errs++;
      $display("FAIL residue_unsigned p=%h: got %0d, required %0d", p, u_residue,
               ref_mod(p, 1'b0));
    end
    vectors++;
    if (s_residue !== 8'(ref_mod(p, 1'b1))) begin
      errs++;
      $display("FAIL residue_signed p=%h: got %0d, required %0d", p, s_residue,
               ref_mod(p, 1'b1));
    end
    hu = u_residue;
    hs = s_residue;
    repeat (hold) begin
      product  = 16'($urandom);
      in_valid = 1'b1;
      @(posedge clock);
      #1;
      vectors++;
      if (u_out_valid !== 1'b1 || s_out_valid !== 1'b1 || u_residue !== hu ||
          s_residue !== hs || u_in_ready !== 1'b0 || s_in_ready !== 1'b0) begin
        errs++;
        $display("FAIL backpressure_hold: ov=%b/%b res=%0d/%0d rdy=%b/%b, required 1/1 %0d/%0d 0/0",
                 u_out_valid, s_out_valid, u_residue, s_residue, u_in_ready, s_in_ready, hu, hs);
      end
    end
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    vectors++;
    if (u_out_valid !== 1'b0 || s_out_valid !== 1'b0 || u_busy !== 1'b0 ||
        s_busy !== 1'b0 || u_in_ready !== 1'b1 || s_in_ready !== 1'b1) begin
      errs++;
      $display("FAIL handshake: ov=%b/%b busy=%b/%b rdy=%b/%b, required 0/0 0/0 1/1",
               u_out_valid, s_out_valid, u_busy, s_busy, u_in_ready, s_in_ready);
    end
  endtask

  task automatic test_reset();
    aclr      = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    product   = '0;
    repeat (2) @(posedge clock);
    #1;
    vectors++;
    if (u_in_ready !== 1'b0 || u_out_valid !== 1'b0 || u_residue !== 8'd0 || u_busy !== 1'b0 ||
        s_in_ready !== 1'b0 || s_out_valid !== 1'b0 || s_residue !== 8'd0 || s_busy !== 1'b0) begin
      errs++;
      $display("FAIL reset_state: rdy=%b ov=%b res=%0d busy=%b, required 0 0 0 0",
               u_in_ready, u_out_valid, u_residue, u_busy);
    end
    @(negedge clock);
    aclr = 1'b0;
    #1;
    vectors++;
    if (u_in_ready !== 1'b1 || s_in_ready !== 1'b1) begin
      errs++;
      $display("FAIL reset_release_ready: got %b/%b, required 1/1", u_in_ready, s_in_ready);
    end
  endtask

  task automatic test_max_latency();
    run_txn(16'hFFFF, 0, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [15:0] seq [4];
    int prev;
    seq[0] = 16'd0;
    seq[1] = 16'd250;
    seq[2] = 16'd251;
    seq[3] = 16'd502;
    run_txn(seq[0], 0, 1'b1);
    prev = acc_cyc;
    for (int i = 1; i < 4; i++) begin
      run_txn(seq[i], 0, 1'b1);
      vectors++;
      if (acc_cyc - prev != 19) begin
        errs++;
        $display("FAIL accept_spacing #%0d: got %0d cycles, required 19", i, acc_cyc - prev);
      end
      prev = acc_cyc;
    end
  endtask

  task automatic test_signed_corners();
    logic [15:0] vals [4];
    vals[0] = 16'hFFFF;
    vals[1] = 16'hFF05;
    vals[2] = 16'h8000;
    vals[3] = 16'h7FFF;
    for (int i = 0; i < 4; i++) run_txn(vals[i], 0, 1'b0);
  endtask

  task automatic test_backpressure();
    run_txn(16'hBEEF, 5, 1'b0);
    run_txn(16'h0FB0, 1, 1'b0);
  endtask

  task automatic test_abort();
    @(negedge clock);
    product  = 16'h1234;
    in_valid = 1'b1;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clock);
    #1;
    aclr = 1'b1;
    #1;
    vectors++;
    if (u_out_valid !== 1'b0 || u_busy !== 1'b0 || u_in_ready !== 1'b0 ||
        s_out_valid !== 1'b0 || s_busy !== 1'b0 || s_in_ready !== 1'b0) begin
      errs++;
      $display("FAIL abort_run: ov=%b busy=%b rdy=%b, required 0 0 0",
               u_out_valid, u_busy, u_in_ready);
    end
    @(negedge clock);
    aclr = 1'b0;
    run_txn(16'd1000, 0, 1'b1);
    // Abort while a residue is pending in DONE.
    @(negedge clock);
    product  = 16'hF00D;
    in_valid = 1'b1;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    repeat (20) @(posedge clock);
    #1;
    aclr = 1'b1;
    #1;
    vectors++;
    if (u_out_valid !== 1'b0 || s_out_valid !== 1'b0 || u_residue !== 8'd0) begin
      errs++;
      $display("FAIL abort_done: ov=%b/%b res=%0d, required 0/0 0",
               u_out_valid, s_out_valid, u_residue);
    end
    @(negedge clock);
    aclr = 1'b0;
    run_txn(16'd1000, 0, 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      run_txn(16'($urandom), int'($urandom_range(0, 3)), 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_max_latency();
    test_back_to_back();
    test_signed_corners();
    test_backpressure();
    test_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
